// File: rtl/branch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// branch_ctrl_pkg
//   Shared definitions for the branch controller: flag bit positions, FSM
//   state codes, the branch-select bundle fed to the resolver and the
//   flag-code clamp helper.
//   Optional feature macro used by the top: BRU_FLAG_FWD_EN.
// ---------------------------------------------------------------------------
package branch_ctrl_pkg;

    localparam int NUM_FLAGS = 6;

    // Flag register bit positions.
    localparam int FL_TRUE = 0;
    localparam int FL_ZERO = 1;
    localparam int FL_MAX  = 5;

    typedef enum logic [1:0] {
        BRC_IDLE      = 2'd0,
        BRC_WAIT_FLAG = 2'd1,
        BRC_FLUSH     = 2'd2
    } brc_state_t;

    // Everything the resolver needs to know about the branch, apart from
    // the flags and the target.
    typedef struct packed {
        logic       sel_jflag;    // 1 = beq/bne, 0 = jt/jf
        logic       sel_jt_jf;    // 1 = jt, 0 = jf
        logic       sel_beq_bne;  // 1 = FL_TRUE, 0 = FL_ZERO
        logic [2:0] flag_idx;     // already clamped to 0..FL_MAX
    } br_sel_t;

    // Flag codes beyond the last implemented flag alias the top flag.
    function automatic logic [2:0] clamp_flag_code(input logic [4:0] code);
        return (code > 5'(FL_MAX)) ? 3'(FL_MAX) : code[2:0];
    endfunction

endpackage

// File: rtl/branch_ctrl_bru.sv
// ---------------------------------------------------------------------------
// bru
//   Purely combinational branch resolver.
//   Ports:
//     flags  in  6      flag vector to test (registered or forwarded)
//     sel    in  struct branch kind / flag index (see branch_ctrl_pkg)
//     taken  out 1      branch condition is true
// ---------------------------------------------------------------------------
module bru
    import branch_ctrl_pkg::*;
(
    input  logic [NUM_FLAGS-1:0] flags,
    input  br_sel_t              sel,
    output logic                 taken
);

    logic [NUM_FLAGS-1:0] shifted;

    always_comb begin
        // Shift instead of a variable bit-select so an index of 6/7 can never
        // read outside the vector; the clamp keeps it in range anyway.
        shifted = flags >> sel.flag_idx;
        taken   = 1'b0;
        if (sel.sel_jflag) begin
            taken = sel.sel_beq_bne ? flags[FL_TRUE] : flags[FL_ZERO];
        end else begin
            taken = sel.sel_jt_jf ? shifted[0] : ~shifted[0];
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// ---------------------------------------------------------------------------
// branch_ctrl
//   Sequences branch resolution between ID and fetch. Owns the architectural
//   flag register, stalls ID for one cycle when the instruction in EX is
//   about to rewrite the flags, resolves through a single bru instance and
//   then redirects the PC and flushes IF/ID for FLUSH_CYCLES cycles.
//
//   Parameters:
//     PC_W          width of PC / branch target
//     FLUSH_CYCLES  cycles flush_if_id stays high after a taken branch (1..7)
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     id_is_branch             ID holds jt/jf/beq/bne
//     id_sel_jflag/_jt_jf/_beq_bne, id_flag_code, id_target
//                              branch decode fields from ID
//     ex_valid, ex_writes_flag EX holds a live, flag-writing instruction
//     alu_flags                flags produced by the ALU this cycle
//     stall_if_id              hold PC and IF/ID
//     flush_if_id              bubble IF/ID
//     pc_redirect, pc_target   one-cycle PC load and its address (0 otherwise)
//     flags_q                  architectural flag register
//
//   Build option BRU_FLAG_FWD_EN: a flag hazard is resolved immediately using
//   the forwarded alu_flags, so no stall is taken and WAIT_FLAG is never
//   entered. Without it, a flag hazard costs one stall cycle.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | no branch in flight; resolve ID branches without hazard
//   WAIT_FLAG | ID stalled one cycle; resolve latched branch on new flags
//   FLUSH     | taken branch still flushing IF/ID; ID branches ignored
// ---------------------------------------------------------------------------
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int PC_W         = 16,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_is_branch,
    input  logic                 id_sel_jflag,
    input  logic                 id_sel_jt_jf,
    input  logic                 id_sel_beq_bne,
    input  logic [4:0]           id_flag_code,
    input  logic [PC_W-1:0]      id_target,
    input  logic                 ex_valid,
    input  logic                 ex_writes_flag,
    input  logic [NUM_FLAGS-1:0] alu_flags,
    output logic                 stall_if_id,
    output logic                 flush_if_id,
    output logic                 pc_redirect,
    output logic [PC_W-1:0]      pc_target,
    output logic [NUM_FLAGS-1:0] flags_q
);

    // The cycle of the redirect is the first flush cycle, so the counter only
    // covers the remaining ones.
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    brc_state_t           state, state_n;
    logic [2:0]           cnt, cnt_n;
    br_sel_t              lat_sel;
    logic [PC_W-1:0]      lat_target;
    logic                 latch_en;

    logic                 flag_wr;
    logic                 hz;
    logic                 use_latched;
    br_sel_t              live_sel;
    br_sel_t              bru_sel;
    logic [NUM_FLAGS-1:0] bru_flags;
    logic                 taken;

    assign flag_wr = ex_valid & ex_writes_flag;
    assign hz      = id_is_branch & flag_wr;

    // Resolver operand muxes: latched fields while waiting on flags, live ID
    // fields otherwise; forwarded flags only for a hazard seen in IDLE.
    always_comb begin
        live_sel             = '0;
        live_sel.sel_jflag   = id_sel_jflag;
        live_sel.sel_jt_jf   = id_sel_jt_jf;
        live_sel.sel_beq_bne = id_sel_beq_bne;
        live_sel.flag_idx    = clamp_flag_code(id_flag_code);

        use_latched = (state == BRC_WAIT_FLAG);
        bru_sel     = use_latched ? lat_sel : live_sel;
`ifdef BRU_FLAG_FWD_EN
        bru_flags   = ((state == BRC_IDLE) && hz) ? alu_flags : flags_q;
`else
        bru_flags   = flags_q;
`endif
    end

    bru u_bru (
        .flags (bru_flags),
        .sel   (bru_sel),
        .taken (taken)
    );

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        latch_en    = 1'b0;
        stall_if_id = 1'b0;
        flush_if_id = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = '0;

        case (state)
            BRC_IDLE: begin
                if (id_is_branch) begin
`ifdef BRU_FLAG_FWD_EN
                    if (taken) begin
                        pc_redirect = 1'b1;
                        pc_target   = id_target;
                        flush_if_id = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_n = BRC_FLUSH;
                            cnt_n   = FLUSH_INIT;
                        end
                    end
`else
                    if (hz) begin
                        stall_if_id = 1'b1;
                        latch_en    = 1'b1;
                        state_n     = BRC_WAIT_FLAG;
                    end else if (taken) begin
                        pc_redirect = 1'b1;
                        pc_target   = id_target;
                        flush_if_id = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_n = BRC_FLUSH;
                            cnt_n   = FLUSH_INIT;
                        end
                    end
`endif
                end
            end

            BRC_WAIT_FLAG: begin
                state_n = BRC_IDLE;
                if (taken) begin
                    pc_redirect = 1'b1;
                    pc_target   = lat_target;
                    flush_if_id = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_n = BRC_FLUSH;
                        cnt_n   = FLUSH_INIT;
                    end
                end
            end

            BRC_FLUSH: begin
                // Leave on the last flush cycle so a branch arriving right
                // after the flush window is resolved without a dead cycle.
                flush_if_id = 1'b1;
                cnt_n       = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    state_n = BRC_IDLE;
                end
            end

            default: begin
                state_n = BRC_IDLE;
                cnt_n   = '0;
            end
        endcase

        // Reset wins over everything, including a branch presented this cycle.
        if (rst) begin
            latch_en    = 1'b0;
            stall_if_id = 1'b0;
            flush_if_id = 1'b0;
            pc_redirect = 1'b0;
            pc_target   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BRC_IDLE;
            cnt        <= '0;
            flags_q    <= '0;
            lat_sel    <= '0;
            lat_target <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (flag_wr) begin
                flags_q <= alu_flags;
            end
            if (latch_en) begin
                lat_sel    <= live_sel;
                lat_target <= id_target;
            end
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;

    logic        clk;
    logic        rst;
    logic        id_is_branch;
    logic        id_sel_jflag;
    logic        id_sel_jt_jf;
    logic        id_sel_beq_bne;
    logic [4:0]  id_flag_code;
    logic [15:0] id_target;
    logic        ex_valid;
    logic        ex_writes_flag;
    logic [5:0]  alu_flags;

    logic        stall1, flush1, redir1;
    logic [15:0] tgt1;
    logic [5:0]  flg1;
    logic        stall3, flush3, redir3;
    logic [15:0] tgt3;
    logic [5:0]  flg3;

    int n_cmp = 0;
    int n_bad = 0;
    bit run   = 0;

    branch_ctrl #(.PC_W(16), .FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .id_is_branch(id_is_branch),
        .id_sel_jflag(id_sel_jflag), .id_sel_jt_jf(id_sel_jt_jf),
        .id_sel_beq_bne(id_sel_beq_bne), .id_flag_code(id_flag_code),
        .id_target(id_target), .ex_valid(ex_valid), .ex_writes_flag(ex_writes_flag),
        .alu_flags(alu_flags), .stall_if_id(stall1), .flush_if_id(flush1),
        .pc_redirect(redir1), .pc_target(tgt1), .flags_q(flg1)
    );

    branch_ctrl #(.PC_W(16), .FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .id_is_branch(id_is_branch),
        .id_sel_jflag(id_sel_jflag), .id_sel_jt_jf(id_sel_jt_jf),
        .id_sel_beq_bne(id_sel_beq_bne), .id_flag_code(id_flag_code),
        .id_target(id_target), .ex_valid(ex_valid), .ex_writes_flag(ex_writes_flag),
        .alu_flags(alu_flags), .stall_if_id(stall3), .flush_if_id(flush3),
        .pc_redirect(redir3), .pc_target(tgt3), .flags_q(flg3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit m_taken(input logic [5:0] f, input bit jflag, input bit jtjf,
                                   input bit beqbne, input int code);
        int idx;
        idx = (code > 5) ? 5 : code;
        if (jflag) return beqbne ? f[0] : f[1];
        return jtjf ? f[idx] : !f[idx];
    endfunction

    int          fc [2] = '{1, 3};
    int          m_flush_left [2] = '{0, 0};
    bit          m_pend [2] = '{0, 0};
    bit          p_jflag [2], p_jtjf [2], p_beqbne [2];
    int          p_code [2];
    logic [15:0] p_tgt [2];
    logic [5:0]  m_flags = '0;

    always @(negedge clk) begin
        if (run) begin
            for (int i = 0; i < 2; i++) begin
                bit          e_stall, e_flush, e_redir;
                logic [15:0] e_tgt;
                bit          hzd;
                e_stall = 0; e_flush = 0; e_redir = 0; e_tgt = '0;
                hzd = ex_valid && ex_writes_flag;
                if (rst) begin
                    m_flush_left[i] = 0;
                    m_pend[i]       = 0;
                end else if (m_flush_left[i] > 0) begin
                    e_flush = 1;
                    m_flush_left[i]--;
                end else if (m_pend[i]) begin
                    m_pend[i] = 0;
                    if (m_taken(m_flags, p_jflag[i], p_jtjf[i], p_beqbne[i], p_code[i])) begin
                        e_redir = 1; e_flush = 1; e_tgt = p_tgt[i];
                        m_flush_left[i] = fc[i] - 1;
                    end
                end else if (id_is_branch) begin
`ifdef BRU_FLAG_FWD_EN
                    if (m_taken(hzd ? alu_flags : m_flags, id_sel_jflag, id_sel_jt_jf,
                                id_sel_beq_bne, int'(id_flag_code))) begin
                        e_redir = 1; e_flush = 1; e_tgt = id_target;
                        m_flush_left[i] = fc[i] - 1;
                    end
`else
                    if (hzd) begin
                        e_stall     = 1;
                        m_pend[i]   = 1;
                        p_jflag[i]  = id_sel_jflag;
                        p_jtjf[i]   = id_sel_jt_jf;
                        p_beqbne[i] = id_sel_beq_bne;
                        p_code[i]   = int'(id_flag_code);
                        p_tgt[i]    = id_target;
                    end else if (m_taken(m_flags, id_sel_jflag, id_sel_jt_jf,
                                         id_sel_beq_bne, int'(id_flag_code))) begin
                        e_redir = 1; e_flush = 1; e_tgt = id_target;
                        m_flush_left[i] = fc[i] - 1;
                    end
`endif
                end
                if (i == 0) begin
                    chk("m1_stall", stall1, e_stall);
                    chk("m1_flush", flush1, e_flush);
                    chk("m1_redirect", redir1, e_redir);
                    chk("m1_target", tgt1, e_tgt);
                    chk("m1_flags", flg1, m_flags);
                end else begin
                    chk("m3_stall", stall3, e_stall);
                    chk("m3_flush", flush3, e_flush);
                    chk("m3_redirect", redir3, e_redir);
                    chk("m3_target", tgt3, e_tgt);
                    chk("m3_flags", flg3, m_flags);
                end
            end
            if (rst) m_flags = '0;
            else if (ex_valid && ex_writes_flag) m_flags = alu_flags;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        id_is_branch   = 0;
        id_sel_jflag   = 0;
        id_sel_jt_jf   = 0;
        id_sel_beq_bne = 0;
        id_flag_code   = '0;
        id_target      = '0;
        ex_valid       = 0;
        ex_writes_flag = 0;
        alu_flags      = '0;
    endtask

    task automatic br(input bit jflag, input bit jtjf, input bit beqbne,
                      input logic [4:0] code, input logic [15:0] tgt);
        id_is_branch   = 1;
        id_sel_jflag   = jflag;
        id_sel_jt_jf   = jtjf;
        id_sel_beq_bne = beqbne;
        id_flag_code   = code;
        id_target      = tgt;
    endtask

    task automatic wr_flags(input logic [5:0] f);
        ex_valid       = 1;
        ex_writes_flag = 1;
        alu_flags      = f;
    endtask

    initial begin
        rst = 1;
        idle_in();
        br(0, 1, 0, 5'd0, 16'hffff);
        run = 1;

        // reset held with a branch presented
        @(negedge clk);
        chk("t1_redirect", redir1, 0);
        chk("t1_flush", flush1, 0);
        chk("t1_stall", stall1, 0);
        chk("t1_target", tgt1, 0);
        step();
        @(negedge clk);
        chk("t1_flags", flg1, 0);
        chk("t1_redirect3", redir3, 0);
        step();

        // bne taken on FL_ZERO, no hazard
        rst = 0;
        idle_in();
        wr_flags(6'b000010);
        step();
        idle_in();
        br(1, 0, 0, 5'd0, 16'h0040);
        @(negedge clk);
        chk("t2_redirect", redir1, 1);
        chk("t2_target", tgt1, 16'h0040);
        chk("t2_flush", flush1, 1);
        chk("t2_stall", stall1, 0);
        chk("t2_flags", flg1, 6'b000010);
        step();
        idle_in();
        repeat (3) step();

        // jt code 3 against a flag-writing EX instruction
        br(0, 1, 0, 5'd3, 16'h1234);
        wr_flags(6'b001000);
        @(negedge clk);
`ifdef BRU_FLAG_FWD_EN
        chk("t3_c0_redirect", redir1, 1);
        chk("t3_c0_stall", stall1, 0);
`else
        chk("t3_c0_stall", stall1, 1);
        chk("t3_c0_redirect", redir1, 0);
        chk("t3_c0_flush", flush1, 0);
`endif
        step();
        ex_valid = 0;
        ex_writes_flag = 0;
        alu_flags = '0;
        @(negedge clk);
`ifndef BRU_FLAG_FWD_EN
        chk("t3_c1_redirect", redir1, 1);
        chk("t3_c1_target", tgt1, 16'h1234);
        chk("t3_c1_flush", flush1, 1);
        chk("t3_c1_stall", stall1, 0);
`endif
        chk("t3_c1_flags", flg1, 6'b001000);
        step();
        idle_in();
        repeat (3) step();

        // flag code clamp: code 7 -> 5 for jf (not taken), code 6 -> 5 for jt (taken)
        wr_flags(6'b100000);
        step();
        idle_in();
        br(0, 0, 0, 5'd7, 16'h0abc);
        @(negedge clk);
        chk("t4_jf_redirect", redir1, 0);
        chk("t4_jf_flush", flush1, 0);
        chk("t4_jf_stall", stall1, 0);
        chk("t4_jf_target", tgt1, 0);
        step();
        br(0, 1, 0, 5'd6, 16'h0abc);
        @(negedge clk);
        chk("t4_jt_redirect", redir1, 1);
        chk("t4_jt_target", tgt1, 16'h0abc);
        step();
        idle_in();
        repeat (3) step();

        // FLUSH_CYCLES=3: branch presented during flush is ignored
        wr_flags(6'b100001);
        step();
        idle_in();
        br(1, 0, 1, 5'd0, 16'h0200);
        @(negedge clk);
        chk("t5_c0_redirect3", redir3, 1);
        chk("t5_c0_target3", tgt3, 16'h0200);
        chk("t5_c0_flush3", flush3, 1);
        step();
        br(0, 1, 0, 5'd0, 16'h0300);
        @(negedge clk);
        chk("t5_c1_flush3", flush3, 1);
        chk("t5_c1_redirect3", redir3, 0);
        chk("t5_c1_target3", tgt3, 0);
        chk("t5_c1_redirect1", redir1, 1);
        chk("t5_c1_target1", tgt1, 16'h0300);
        step();
        @(negedge clk);
        chk("t5_c2_flush3", flush3, 1);
        chk("t5_c2_redirect3", redir3, 0);
        step();
        idle_in();
        @(negedge clk);
        chk("t5_c3_flush3", flush3, 0);
        chk("t5_c3_redirect3", redir3, 0);
        repeat (2) step();

        // reset pulsed while waiting on flags
        br(0, 1, 0, 5'd3, 16'h0555);
        wr_flags(6'b001000);
        @(negedge clk);
`ifndef BRU_FLAG_FWD_EN
        chk("t6_c0_stall", stall1, 1);
`endif
        step();
        rst = 1;
        idle_in();
        @(negedge clk);
        chk("t6_c1_redirect", redir1, 0);
        chk("t6_c1_stall", stall1, 0);
        step();
        rst = 0;
        @(negedge clk);
        chk("t6_c2_redirect", redir1, 0);
        chk("t6_c2_stall", stall1, 0);
        chk("t6_c2_flush", flush1, 0);
        chk("t6_c2_flags", flg1, 0);
        chk("t6_c2_redirect3", redir3, 0);
        repeat (2) step();

        @(negedge clk);
        run = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
